// File: rtl/fp_unit_arbiter.sv
// fp_unit_arbiter
//   Shares one fixed-latency, in-order, pipelined float32 unit (adder or
//   multiplier) between NUM_REQ requesters. It grants one issue slot per cycle,
//   remembers the owner of every in-flight operation in a tag FIFO, and steers
//   each returning result back to that owner.
//
//   Build option: define FP_ARB_FIXED_PRIO_EN to use fixed priority instead of
//   round-robin. With fixed priority the lowest-index valid requester always
//   wins. Without the macro, arbitration is round-robin.
//
//   Ports
//     clk_in, rst_in    clock, synchronous active-high reset
//     req_valid_in      per-requester operation request
//     req_a_in/b_in     per-requester float32 operands
//     req_ready_out     one-hot grant (transfer = valid & ready)
//     resp_valid_out    one-hot 1-cycle result strobe to the owner
//     resp_data_out     result data, shared by all requesters
//     unit_a/b_out      operands to the FP unit
//     unit_valid_out    tvalid to the FP unit
//     unit_result_in    result tdata from the FP unit
//     unit_valid_in     result tvalid from the FP unit
//     busy_out          operations outstanding or post-reset flush active
//     orphan_err_out    sticky: a result arrived with no tag outstanding
module fp_unit_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned LATENCY   = 11,
  parameter int unsigned TAG_DEPTH = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [NUM_REQ-1:0]      req_valid_in,
  input  logic [NUM_REQ-1:0][31:0] req_a_in,
  input  logic [NUM_REQ-1:0][31:0] req_b_in,
  output logic [NUM_REQ-1:0]      req_ready_out,
  output logic [NUM_REQ-1:0]      resp_valid_out,
  output logic [31:0]             resp_data_out,
  output logic [31:0]             unit_a_out,
  output logic [31:0]             unit_b_out,
  output logic                    unit_valid_out,
  input  logic [31:0]             unit_result_in,
  input  logic                    unit_valid_in,
  output logic                    busy_out,
  output logic                    orphan_err_out
);

  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned AW  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned CW  = $clog2(TAG_DEPTH + 1);
  localparam int unsigned FW  = $clog2(LATENCY + 1);

  logic [FW-1:0]      r_flush;
  logic [CW-1:0]      r_count;
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [IDW-1:0]     r_tags [TAG_DEPTH];

  logic [31:0]        r_unit_a;
  logic [31:0]        r_unit_b;
  logic               r_unit_valid;
  logic [NUM_REQ-1:0] r_resp_valid;
  logic [31:0]        r_resp_data;
  logic               r_busy;
  logic               r_orphan;

  logic [IDW-1:0]     w_start;
  logic               w_issue_ok;
  logic               w_found;
  logic [IDW-1:0]     w_grant_id;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_push;
  logic               w_pop;
  logic               w_orphan;

`ifdef FP_ARB_FIXED_PRIO_EN
  assign w_start = '0;
`else
  logic [IDW-1:0] r_rr;
  assign w_start = r_rr;
`endif

  // Full is judged on the registered count, so a pop in the same cycle only
  // frees a slot from the following cycle on.
  assign w_issue_ok = (r_flush == '0) && (r_count < CW'(TAG_DEPTH));

  // Scan from the start pointer upward, wrapping modulo NUM_REQ.
  always_comb begin
    w_found    = 1'b0;
    w_grant_id = '0;
    if (w_issue_ok) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (!w_found && req_valid_in[IDW'((32'(w_start) + k) % NUM_REQ)]) begin
          w_found    = 1'b1;
          w_grant_id = IDW'((32'(w_start) + k) % NUM_REQ);
        end
      end
    end
  end

  assign w_grant  = w_found ? (NUM_REQ'(1) << w_grant_id) : '0;
  assign w_push   = w_found;
  // Results are only accepted once the flush window has closed.
  assign w_pop    = unit_valid_in && (r_flush == '0) && (r_count != '0);
  assign w_orphan = unit_valid_in && (r_flush == '0) && (r_count == '0);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_flush      <= FW'(LATENCY);
      r_count      <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
`ifndef FP_ARB_FIXED_PRIO_EN
      r_rr         <= '0;
`endif
      r_unit_a     <= '0;
      r_unit_b     <= '0;
      r_unit_valid <= 1'b0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      r_busy       <= 1'b0;
      r_orphan     <= 1'b0;
    end else begin
      if (r_flush != '0) begin
        r_flush <= r_flush - FW'(1);
      end

      r_unit_valid <= w_push;
      if (w_push) begin
        r_unit_a         <= req_a_in[w_grant_id];
        r_unit_b         <= req_b_in[w_grant_id];
        r_tags[r_wptr]   <= w_grant_id;
        r_wptr           <= r_wptr + AW'(1);
`ifndef FP_ARB_FIXED_PRIO_EN
        r_rr <= (w_grant_id == IDW'(NUM_REQ - 1)) ? '0 : w_grant_id + IDW'(1);
`endif
      end

      r_resp_valid <= '0;
      if (w_pop) begin
        r_resp_valid <= NUM_REQ'(1) << r_tags[r_rptr];
        r_resp_data  <= unit_result_in;
        r_rptr       <= r_rptr + AW'(1);
      end

      if (w_orphan) begin
        r_orphan <= 1'b1;
      end

      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end

      // Registered view of the current occupancy and flush state.
      r_busy <= (r_count != '0) || (r_flush != '0);
    end
  end

  assign req_ready_out  = w_grant;
  assign resp_valid_out = r_resp_valid;
  assign resp_data_out  = r_resp_data;
  assign unit_a_out     = r_unit_a;
  assign unit_b_out     = r_unit_b;
  assign unit_valid_out = r_unit_valid;
  assign busy_out       = r_busy;
  assign orphan_err_out = r_orphan;

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// tb_fp_unit_arbiter
//   Bench for fp_unit_arbiter with a float32 adder model behind it.
//   Expected values come from a cycle-level reference model held in queues.
module tb_fp_unit_arbiter;

  localparam int NR  = 4;
  localparam int LAT = 11;
  localparam int TD  = 16;

  logic                clk_in = 1'b0;
  logic                rst_in;
  logic [NR-1:0]       req_valid_in;
  logic [NR-1:0][31:0] req_a_in;
  logic [NR-1:0][31:0] req_b_in;
  logic [NR-1:0]       req_ready_out;
  logic [NR-1:0]       resp_valid_out;
  logic [31:0]         resp_data_out;
  logic [31:0]         unit_a_out;
  logic [31:0]         unit_b_out;
  logic                unit_valid_out;
  logic [31:0]         unit_result_in;
  logic                unit_valid_in;
  logic                busy_out;
  logic                orphan_err_out;

  always #5 clk_in = ~clk_in;

  fp_unit_arbiter #(.NUM_REQ(NR), .LATENCY(LAT), .TAG_DEPTH(TD)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_valid_in(req_valid_in), .req_a_in(req_a_in), .req_b_in(req_b_in),
    .req_ready_out(req_ready_out), .resp_valid_out(resp_valid_out),
    .resp_data_out(resp_data_out), .unit_a_out(unit_a_out),
    .unit_b_out(unit_b_out), .unit_valid_out(unit_valid_out),
    .unit_result_in(unit_result_in), .unit_valid_in(unit_valid_in),
    .busy_out(busy_out), .orphan_err_out(orphan_err_out)
  );

  // float32 <-> real for normal numbers (denormals treated as zero)
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e;
    if (f[30:23] == 8'd0) return 0.0;
    e = 11'(f[30:23]) + 11'd896;
    d = {f[31], e, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic logic [31:0] rand_f();
    logic [7:0] ex;
    ex = 8'(120 + $urandom_range(0, 14));
    return {1'($urandom_range(0, 1)), ex, 23'($urandom)};
  endfunction

  // FP unit model: fixed latency LAT, in order; 'stall' holds results back.
  typedef struct { int due; logic [31:0] data; } fpop_t;
  fpop_t       fpq[$];
  int          edge_n = 0;
  logic        stall  = 1'b0;
  logic        fp_v   = 1'b0;
  logic [31:0] fp_d   = '0;
  logic        inj_v  = 1'b0;

  always @(posedge clk_in) begin
    edge_n <= edge_n + 1;
    if (unit_valid_out === 1'b1)
      fpq.push_back('{edge_n + LAT - 1, fadd(unit_a_out, unit_b_out)});
    if (fpq.size() > 0 && fpq[0].due <= edge_n && !stall) begin
      fp_v <= 1'b1;
      fp_d <= fpq[0].data;
      void'(fpq.pop_front());
    end else begin
      fp_v <= 1'b0;
    end
  end

  assign unit_valid_in  = fp_v | inj_v;
  assign unit_result_in = inj_v ? 32'hdeadbeef : fp_d;

  // Reference model state
  typedef struct { int owner; logic [31:0] sum; } tag_t;
  tag_t          mq[$];
  int            m_rr, m_flush;
  logic          m_orphan;
  logic          e_uv, e_busy;
  logic [31:0]   e_a, e_b, e_rd;
  logic [NR-1:0] e_rv;
  int            passes = 0;
  int            total  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    m_rr = 0; m_flush = LAT; m_orphan = 1'b0;
    e_uv = 1'b0; e_busy = 1'b0; e_a = '0; e_b = '0; e_rd = '0; e_rv = '0;
  endtask

  // Check one cycle against the model, advance the model, cross one edge.
  task automatic step();
    logic [NR-1:0] e_ready;
    int   win, idx;
    tag_t h;
    #1;
    e_ready = '0;
    win = -1;
    if (m_flush == 0 && mq.size() < TD) begin
      for (int k = 0; k < NR; k++) begin
`ifdef FP_ARB_FIXED_PRIO_EN
        idx = k;
`else
        idx = (m_rr + k) % NR;
`endif
        if (win < 0 && req_valid_in[idx]) win = idx;
      end
    end
    if (win >= 0) e_ready[win] = 1'b1;

    chk("ready", 32'(req_ready_out), 32'(e_ready));
    chk("unit_valid", 32'(unit_valid_out), 32'(e_uv));
    chk("unit_a", unit_a_out, e_a);
    chk("unit_b", unit_b_out, e_b);
    chk("resp_valid", 32'(resp_valid_out), 32'(e_rv));
    if (e_rv != '0) chk("resp_data", resp_data_out, e_rd);
    chk("busy", 32'(busy_out), 32'(e_busy));
    chk("orphan", 32'(orphan_err_out), 32'(m_orphan));

    if (rst_in) begin
      model_reset();
    end else begin
      e_busy = (mq.size() != 0) || (m_flush != 0);
      e_rv = '0;
      if (unit_valid_in && m_flush == 0) begin
        if (mq.size() > 0) begin
          h = mq.pop_front();
          e_rv = NR'(1) << h.owner;
          e_rd = h.sum;
        end else begin
          m_orphan = 1'b1;
        end
      end
      if (win >= 0) begin
        e_uv = 1'b1;
        e_a  = req_a_in[win];
        e_b  = req_b_in[win];
        mq.push_back('{win, fadd(req_a_in[win], req_b_in[win])});
`ifndef FP_ARB_FIXED_PRIO_EN
        m_rr = (win + 1) % NR;
`endif
      end else begin
        e_uv = 1'b0;
      end
      if (m_flush > 0) m_flush--;
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NR; i++) begin
      req_a_in[i] = rand_f();
      req_b_in[i] = rand_f();
    end
  endtask

  initial begin
    rst_in = 1'b1; req_valid_in = '0; req_a_in = '0; req_b_in = '0;
    @(posedge clk_in);
    #1;
    model_reset();
    step(); step();
    rst_in = 1'b0;
    repeat (LAT + 3) step();

    // single request from requester 2: 1.0 + 2.0
    req_valid_in = 4'b0100;
    req_a_in[2] = 32'h3f800000;
    req_b_in[2] = 32'h40000000;
    #1 chk("single_ready", 32'(req_ready_out), 32'h4);
    step();
    req_valid_in = '0;
    repeat (12) step();
    chk("single_resp_valid", 32'(resp_valid_out), 32'h4);
    chk("single_resp_data", resp_data_out, 32'h40400000);
    repeat (2) step();

    // contention: everyone valid every cycle
    req_valid_in = '1;
    repeat (24) begin rand_ops(); step(); end
    req_valid_in = '0;
    repeat (LAT + 4) step();

    // random traffic
    repeat (80) begin
      req_valid_in = NR'($urandom);
      rand_ops();
      step();
    end
    req_valid_in = '0;
    repeat (LAT + 4) step();

    // fill the tag FIFO while results are held back
    stall = 1'b1;
    req_valid_in = '1;
    repeat (LAT + TD + 4) begin rand_ops(); step(); end
    chk("full_ready", 32'(req_ready_out), 32'h0);
    stall = 1'b0;
    step();
    stall = 1'b1;
    step();
    chk("refill_grant", 32'(|req_ready_out), 32'h1);
    repeat (3) begin rand_ops(); step(); end
    stall = 1'b0;
    req_valid_in = '0;
    repeat (TD + LAT + 4) step();

    // reset with 5 operations in flight
    req_valid_in = '1;
    repeat (5) begin rand_ops(); step(); end
    req_valid_in = '0;
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    chk("flush_busy_low_at_reset", 32'(busy_out), 32'h0);
    repeat (3) step();
    chk("flush_busy_high", 32'(busy_out), 32'h1);
    repeat (LAT) step();
    chk("flush_busy_done", 32'(busy_out), 32'h0);
    chk("flush_no_orphan", 32'(orphan_err_out), 32'h0);

    // orphan result with nothing outstanding
    inj_v = 1'b1;
    step();
    inj_v = 1'b0;
    chk("orphan_set", 32'(orphan_err_out), 32'h1);
    chk("orphan_no_resp", 32'(resp_valid_out), 32'h0);
    repeat (5) step();
    chk("orphan_sticky", 32'(orphan_err_out), 32'h1);

    repeat (30) begin
      req_valid_in = NR'($urandom);
      rand_ops();
      step();
    end
    req_valid_in = '0;
    repeat (LAT + 4) step();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
